// File: rtl/ecpri_pkg.sv
// ecpri_pkg -- shared constants and types for the eCPRI remote-memory receive path.
//   * Ethernet / eCPRI header codes checked on every received frame.
//   * Byte offsets of each header field inside the receive frame.
//   * FSM state encoding of ecpri_rx (also exported on its debug port).
package ecpri_pkg;

  localparam logic [15:0] ECPRI_ETHERTYPE = 16'hAEFE;
  localparam logic [3:0]  ECPRI_REVISION  = 4'd1;
  localparam logic [7:0]  MSG_REMOTE_MEM  = 8'h04;

  // R/W field (upper nibble of byte 19)
  localparam logic [3:0]  RW_READ     = 4'd0;
  localparam logic [3:0]  RW_WRITE    = 4'd1;
  localparam logic [3:0]  RW_WRITE_NR = 4'd2;

  // Req/Resp field (lower nibble of byte 19)
  localparam logic [3:0]  RR_REQUEST  = 4'd0;
  localparam logic [3:0]  RR_RESPONSE = 4'd1;

  // Byte offsets inside the received frame; multi-byte fields are big-endian.
  localparam logic [4:0]  OFF_ETHERTYPE    = 5'd12;
  localparam logic [4:0]  OFF_REVISION     = 5'd14;
  localparam logic [4:0]  OFF_MSG_TYPE     = 5'd15;
  localparam logic [4:0]  OFF_PAYLOAD_SIZE = 5'd16;
  localparam logic [4:0]  OFF_RMA_ID       = 5'd18;
  localparam logic [4:0]  OFF_RW_RR        = 5'd19;
  localparam logic [4:0]  OFF_ELEMENT_ID   = 5'd20;
  localparam logic [4:0]  OFF_ADDRESS      = 5'd22;
  localparam logic [4:0]  OFF_LENGTH       = 5'd28;
  localparam logic [4:0]  OFF_DATA         = 5'd30;
  localparam logic [4:0]  HDR_BYTES        = 5'd30;

  // eCPRI payload size counts the 12 remote-memory header bytes ahead of the data.
  localparam logic [15:0] LEN_OVERHEAD = 16'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HDR,
    S_CHECK,
    S_WR_DATA,
    S_RESP,
    S_WAIT_LOW
  } state_e;

  // length <= payload_size - 12, evaluated without underflow.
  function automatic logic len_fits(input logic [15:0] len, input logic [15:0] psize);
    return ({1'b0, len} + {1'b0, LEN_OVERHEAD}) <= {1'b0, psize};
  endfunction

endpackage

// File: rtl/ecpri_rx.sv
// ecpri_rx -- eCPRI remote-memory-access request receiver.
// Reads one frame from the receive RAM, copies its 30 header bytes into the
// header RAM, validates the request and, for writes, copies the data bytes
// into the CPRI payload RAM. Reads and acknowledged writes raise a one-cycle
// response request toward the TX block.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   recv_pkt              level: a frame sits in the receive RAM from address 0
//   inp_data_fifo         reserved, unused
//   addr_1/we_1/oe_1/data_1  receive-frame RAM (read only, data_1 never driven)
//   addr_0/we_0/oe_0/data_0  header RAM (write only)
//   addr_2/we_2/oe_2/data_2  payload RAM (write only)
//   send_write_resp, send_read_resp  one-cycle response requests
//   resp_payload_len      length reported with the last response, held
//   dbg_state             current FSM state
//
// Handshake: recv_pkt is a level request with no ready. Exactly one frame is
// processed per assertion; the block then waits for recv_pkt to drop before
// it will look at the receive RAM again.
module ecpri_rx
  import ecpri_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  recv_pkt,
  input  logic [DATA_WIDTH-1:0] inp_data_fifo,
  output logic [ADDR_WIDTH-1:0] addr_1,
  output logic                  we_1,
  output logic                  oe_1,
  inout  wire  [DATA_WIDTH-1:0] data_1,
  output logic [ADDR_WIDTH-1:0] addr_0,
  output logic                  we_0,
  output logic                  oe_0,
  inout  wire  [DATA_WIDTH-1:0] data_0,
  output logic [ADDR_WIDTH-1:0] addr_2,
  output logic                  we_2,
  output logic                  oe_2,
  inout  wire  [DATA_WIDTH-1:0] data_2,
  output logic                  send_write_resp,
  output logic                  send_read_resp,
  output logic [DATA_WIDTH-1:0] resp_payload_len,
  output state_e                dbg_state
);

  state_e                state_q, state_d;
  logic [16:0]           cnt_q, cnt_d;
  logic [15:0]           eth_q, eth_d;
  logic [3:0]            rev_q, rev_d;
  logic [7:0]            type_q, type_d;
  logic [15:0]           psize_q, psize_d;
  logic [3:0]            rw_q, rw_d;
  logic [3:0]            rr_q, rr_d;
  logic [15:0]           addr_q, addr_d;
  logic [15:0]           len_q, len_d;
  logic [DATA_WIDTH-1:0] resp_len_q, resp_len_d;

  logic        hdr_rd, hdr_wr, pl_rd, pl_wr;
  logic [4:0]  hdr_idx;
  logic [15:0] pl_ofs;
  logic [7:0]  byte_in;
  logic        frame_ok;
  logic        unused_inputs;

  assign unused_inputs = ^inp_data_fifo;
  assign byte_in       = data_1[7:0];

  // Reads are issued one cycle ahead of the matching write because the RAM
  // returns data a cycle after the address; cnt_q counts issued reads, so
  // the write in the same cycle handles byte cnt_q-1.
  assign hdr_rd  = (state_q == S_RD_HDR)  && (cnt_q < {12'd0, HDR_BYTES});
  assign hdr_wr  = (state_q == S_RD_HDR)  && (cnt_q != 17'd0);
  assign pl_rd   = (state_q == S_WR_DATA) && (cnt_q < {1'b0, len_q});
  assign pl_wr   = (state_q == S_WR_DATA) && (cnt_q != 17'd0);
  assign hdr_idx = cnt_q[4:0] - 5'd1;
  assign pl_ofs  = cnt_q[15:0] - 16'd1;

  assign addr_1 = hdr_rd ? ADDR_WIDTH'(cnt_q[4:0]) :
                  pl_rd  ? ADDR_WIDTH'({11'd0, OFF_DATA} + cnt_q[15:0]) : '0;
  assign oe_1   = hdr_rd || pl_rd;
  assign we_1   = 1'b0;

  assign addr_0 = hdr_wr ? ADDR_WIDTH'(hdr_idx) : '0;
  assign we_0   = hdr_wr;
  assign oe_0   = 1'b0;
  assign data_0 = we_0 ? data_1 : 'z;

  // Payload address wraps modulo 2^16 through the 16-bit sum.
  assign addr_2 = pl_wr ? ADDR_WIDTH'(addr_q + pl_ofs) : '0;
  assign we_2   = pl_wr;
  assign oe_2   = 1'b0;
  assign data_2 = we_2 ? data_1 : 'z;

  assign frame_ok = (eth_q == ECPRI_ETHERTYPE) && (rev_q == ECPRI_REVISION) &&
                    (type_q == MSG_REMOTE_MEM) && (rr_q == RR_REQUEST) &&
                    ((rw_q == RW_READ) || (rw_q == RW_WRITE) || (rw_q == RW_WRITE_NR)) &&
                    len_fits(len_q, psize_q);

  assign send_write_resp  = (state_q == S_RESP) && (rw_q == RW_WRITE);
  assign send_read_resp   = (state_q == S_RESP) && (rw_q == RW_READ);
  assign resp_payload_len = resp_len_q;
  assign dbg_state        = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    eth_d      = eth_q;
    rev_d      = rev_q;
    type_d     = type_q;
    psize_d    = psize_q;
    rw_d       = rw_q;
    rr_d       = rr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    resp_len_d = resp_len_q;

    case (state_q)
      S_IDLE: begin
        if (recv_pkt) begin
          state_d = S_RD_HDR;
          cnt_d   = '0;
        end
      end
      S_RD_HDR: begin
        cnt_d = cnt_q + 17'd1;
        if (cnt_q == {12'd0, HDR_BYTES}) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (!frame_ok)                            state_d = S_WAIT_LOW;
        else if (rw_q == RW_READ || len_q == '0)  state_d = S_RESP;
        else                                      state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        cnt_d = cnt_q + 17'd1;
        if (cnt_q == {1'b0, len_q}) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!recv_pkt) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Header fields are captured from the same returning bytes that feed the
    // header copy; multi-byte fields shift in MSB first, so the 48-bit
    // address keeps only its last (low) 16 bits.
    if (hdr_wr) begin
      if (hdr_idx == OFF_ETHERTYPE || hdr_idx == OFF_ETHERTYPE + 5'd1)
        eth_d = {eth_q[7:0], byte_in};
      if (hdr_idx == OFF_REVISION)
        rev_d = byte_in[7:4];
      if (hdr_idx == OFF_MSG_TYPE)
        type_d = byte_in;
      if (hdr_idx == OFF_PAYLOAD_SIZE || hdr_idx == OFF_PAYLOAD_SIZE + 5'd1)
        psize_d = {psize_q[7:0], byte_in};
      if (hdr_idx == OFF_RW_RR) begin
        rw_d = byte_in[7:4];
        rr_d = byte_in[3:0];
      end
      if (hdr_idx >= OFF_ADDRESS && hdr_idx < OFF_LENGTH)
        addr_d = {addr_q[7:0], byte_in};
      if (hdr_idx >= OFF_LENGTH)
        len_d = {len_q[7:0], byte_in};
    end

    // Updated on entry to RESP so the value is already valid during the pulse.
    if (state_d == S_RESP && state_q != S_RESP) begin
      if (rw_q == RW_READ)       resp_len_d = DATA_WIDTH'(len_q[7:0]);
      else if (rw_q == RW_WRITE) resp_len_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      eth_q      <= '0;
      rev_q      <= '0;
      type_q     <= '0;
      psize_q    <= '0;
      rw_q       <= '0;
      rr_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      resp_len_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      eth_q      <= eth_d;
      rev_q      <= rev_d;
      type_q     <= type_d;
      psize_q    <= psize_d;
      rw_q       <= rw_d;
      rr_q       <= rr_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      resp_len_q <= resp_len_d;
    end
  end

endmodule

// File: tb/tb_ecpri_rx.sv
// tb_ecpri_rx -- bench for ecpri_rx: external RAM models, monitor logs,
// a frame-level reference model and directed plus randomized scenarios.
module tb_ecpri_rx;
  import ecpri_pkg::*;

  localparam int DW = 8;
  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic recv_pkt = 1'b0;
  logic [DW-1:0] inp_data_fifo = '0;
  always #5 clk = ~clk;

  logic [AW-1:0] addr_0, addr_1, addr_2;
  logic we_0, we_1, we_2, oe_0, oe_1, oe_2;
  wire  [DW-1:0] data_0, data_1, data_2;
  logic send_write_resp, send_read_resp;
  logic [DW-1:0] resp_payload_len;
  state_e dbg_state;

  ecpri_rx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .recv_pkt(recv_pkt), .inp_data_fifo(inp_data_fifo),
    .addr_1(addr_1), .we_1(we_1), .oe_1(oe_1), .data_1(data_1),
    .addr_0(addr_0), .we_0(we_0), .oe_0(oe_0), .data_0(data_0),
    .addr_2(addr_2), .we_2(we_2), .oe_2(oe_2), .data_2(data_2),
    .send_write_resp(send_write_resp), .send_read_resp(send_read_resp),
    .resp_payload_len(resp_payload_len), .dbg_state(dbg_state)
  );

  // ---------------- RAM models and monitor ----------------
  logic [7:0]  frame_mem [0:65535];
  logic [7:0]  rd_q = '0;
  logic [23:0] pl_log[$];
  logic [23:0] hdr_log[$];
  int          wr_pulses = 0;
  int          rd_pulses = 0;
  int          viol = 0;
  logic [7:0]  last_pulse_len = '0;

  assign data_1 = rd_q;

  always @(posedge clk) begin
    if (oe_1 && !we_1) rd_q <= frame_mem[addr_1];
    if (we_0) hdr_log.push_back({addr_0, data_0});
    if (we_2) pl_log.push_back({addr_2, data_2});
    if (send_write_resp) begin wr_pulses++; last_pulse_len = resp_payload_len; end
    if (send_read_resp)  begin rd_pulses++; last_pulse_len = resp_payload_len; end
    if (we_1 || (we_0 && we_2) || (we_0 && oe_0) || (we_2 && oe_2) || (send_write_resp && send_read_resp))
      viol++;
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  fr[$];
  logic [23:0] exp_q[$];
  int          exp_wr, exp_rd;
  logic [7:0]  exp_pulse_len;
  logic [7:0]  model_resp_len = '0;

  task automatic make_frame(input logic [15:0] eth, input logic [7:0] rev, input logic [7:0] typ,
                            input logic [7:0] rwrr, input logic [15:0] psize,
                            input logic [15:0] addr, input logic [15:0] len);
    fr.delete();
    for (int i = 0; i < 12; i++) fr.push_back(8'($urandom));
    fr.push_back(eth[15:8]);   fr.push_back(eth[7:0]);
    fr.push_back(rev);         fr.push_back(typ);
    fr.push_back(psize[15:8]); fr.push_back(psize[7:0]);
    fr.push_back(8'($urandom));
    fr.push_back(rwrr);
    fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) fr.push_back(8'($urandom));
    fr.push_back(addr[15:8]);  fr.push_back(addr[7:0]);
    fr.push_back(len[15:8]);   fr.push_back(len[7:0]);
    for (int i = 0; i < int'(len); i++) fr.push_back(8'($urandom));
  endtask

  // Expected effect of the frame in fr, straight from the request rules.
  task automatic model_frame();
    logic [15:0] eth, psize, addr, len;
    int rw;
    bit valid;
    eth   = {fr[12], fr[13]};
    psize = {fr[16], fr[17]};
    addr  = {fr[26], fr[27]};
    len   = {fr[28], fr[29]};
    rw    = int'(fr[19] >> 4);
    valid = (eth == 16'hAEFE) && ((fr[14] >> 4) == 8'd1) && (fr[15] == 8'h04) &&
            ((fr[19] & 8'h0F) == 8'd0) && (rw <= 2) && (int'(len) <= int'(psize) - 12);
    exp_q.delete();
    exp_wr = 0;
    exp_rd = 0;
    exp_pulse_len = '0;
    if (valid) begin
      if (rw != 0)
        for (int k = 0; k < int'(len); k++) exp_q.push_back({16'(addr + 16'(k)), fr[30 + k]});
      if (rw == 1) begin exp_wr = 1; exp_pulse_len = 8'd0; model_resp_len = 8'd0; end
      if (rw == 0) begin exp_rd = 1; exp_pulse_len = len[7:0]; model_resp_len = len[7:0]; end
    end
  endtask

  task automatic load_frame();
    for (int i = 0; i < fr.size(); i++) frame_mem[i] = fr[i];
  endtask

  task automatic check_frame(input string name, input int p0, input int h0, input int w0, input int r0);
    int bad;
    // header copy: exactly bytes 0..29 at matching addresses
    bad = 0;
    if (hdr_log.size() - h0 != 30) bad = 1000;
    else for (int i = 0; i < 30; i++) if (hdr_log[h0 + i] !== {16'(i), fr[i]}) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s hdr_copy: got %0d writes with %0d bad entries, want 30 exact", name, hdr_log.size() - h0, bad);
    end
    // payload writes
    bad = 0;
    if (pl_log.size() - p0 != exp_q.size()) bad = 1000;
    else for (int i = 0; i < exp_q.size(); i++) if (pl_log[p0 + i] !== exp_q[i]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s payload: got %0d writes (%0d bad), want %0d", name, pl_log.size() - p0, bad, exp_q.size());
    end
    n_cmp++;
    if (wr_pulses - w0 !== exp_wr) begin
      n_fail++;
      $display("FAIL %s write_resp_pulses: got %0d want %0d", name, wr_pulses - w0, exp_wr);
    end
    n_cmp++;
    if (rd_pulses - r0 !== exp_rd) begin
      n_fail++;
      $display("FAIL %s read_resp_pulses: got %0d want %0d", name, rd_pulses - r0, exp_rd);
    end
    if (exp_wr + exp_rd > 0) begin
      n_cmp++;
      if (last_pulse_len !== exp_pulse_len) begin
        n_fail++;
        $display("FAIL %s pulse_len: got %0d want %0d", name, last_pulse_len, exp_pulse_len);
      end
    end
    n_cmp++;
    if (resp_payload_len !== model_resp_len) begin
      n_fail++;
      $display("FAIL %s resp_len_hold: got %0d want %0d", name, resp_payload_len, model_resp_len);
    end
    n_cmp++;
    if (dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got %0d want %0d", name, dbg_state, S_IDLE);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_frame(input string name, input int hold);
    int p0, h0, w0, r0;
    load_frame();
    model_frame();
    p0 = pl_log.size(); h0 = hdr_log.size(); w0 = wr_pulses; r0 = rd_pulses;
    @(negedge clk) recv_pkt = 1'b1;
    repeat (hold) @(negedge clk);
    recv_pkt = 1'b0;
    repeat (4) @(negedge clk);
    check_frame(name, p0, h0, w0, r0);
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if ({addr_0, addr_1, addr_2, we_0, we_1, we_2, oe_0, oe_1, oe_2,
         send_write_resp, send_read_resp, resp_payload_len} !== '0 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL %s: addr0=%h addr1=%h addr2=%h we=%b%b%b oe=%b%b%b pulses=%b%b len=%0d state=%0d, want all zero/IDLE",
               name, addr_0, addr_1, addr_2, we_0, we_1, we_2, oe_0, oe_1, oe_2,
               send_write_resp, send_read_resp, resp_payload_len, dbg_state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    model_resp_len = 8'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    make_frame(16'hAEFE, 8'h10, 8'h04, 8'h10, 16'd16, 16'h0010, 16'd4);
    fr[30] = 8'hAA; fr[31] = 8'hBB; fr[32] = 8'hCC; fr[33] = 8'hDD;
    run_frame("write_len4", 50);
  endtask

  task automatic test_read();
    make_frame(16'hAEFE, 8'h10, 8'h04, 8'h00, 16'd20, 16'h1234, 16'd8);
    run_frame("read_len8", 50);
  endtask

  task automatic test_bad_ethertype();
    make_frame(16'h0800, 8'h10, 8'h04, 8'h10, 16'd16, 16'h0020, 16'd4);
    run_frame("bad_ethertype", 50);
  endtask

  task automatic test_write_nr_wrap();
    make_frame(16'hAEFE, 8'h10, 8'h04, 8'h20, 16'd14, 16'hFFFF, 16'd2);
    run_frame("write_nr_wrap", 50);
  endtask

  task automatic test_reset_mid_frame();
    int p0, h0, w0, r0;
    make_frame(16'hAEFE, 8'h10, 8'h04, 8'h10, 16'd17, 16'h0400, 16'd5);
    load_frame();
    @(negedge clk) recv_pkt = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset_mid_frame");
    model_resp_len = 8'd0;
    @(negedge clk);
    model_frame();
    p0 = pl_log.size(); h0 = hdr_log.size(); w0 = wr_pulses; r0 = rd_pulses;
    reset = 1'b1;
    repeat (50) @(negedge clk);
    recv_pkt = 1'b0;
    repeat (4) @(negedge clk);
    check_frame("reprocess_after_reset", p0, h0, w0, r0);
  endtask

  task automatic test_long_hold();
    make_frame(16'hAEFE, 8'h10, 8'h04, 8'h00, 16'd15, 16'h0000, 16'd3);
    run_frame("long_hold_200", 200);
  endtask

  task automatic test_random();
    logic [15:0] eth, psize, addr, len;
    logic [7:0]  rev, typ;
    logic [3:0]  rw, rr;
    int mode;
    for (int it = 0; it < 24; it++) begin
      mode  = $urandom_range(0, 9);
      len   = 16'($urandom_range(0, 16));
      rw    = 4'($urandom_range(0, 2));
      rr    = 4'd0;
      psize = len + 16'd12 + 16'($urandom_range(0, 3));
      eth   = 16'hAEFE;
      rev   = {4'd1, 4'($urandom_range(0, 15))};
      typ   = 8'h04;
      addr  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(16'hFFF8 + 16'($urandom_range(0, 7)));
      case (mode)
        0: eth   = 16'(16'h88F7 + 16'($urandom_range(0, 3)));
        1: rev   = {4'($urandom_range(2, 15)), 4'd0};
        2: typ   = 8'($urandom_range(5, 255));
        3: rr    = 4'($urandom_range(1, 15));
        4: rw    = 4'($urandom_range(3, 15));
        5: psize = len + 16'd11;
        default: ;
      endcase
      make_frame(eth, rev, typ, {rw, rr}, psize, addr, len);
      run_frame($sformatf("random_%0d_mode%0d", it, mode), 45 + int'(len));
    end
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL port_invariants: got %0d violating cycles, want 0", viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) frame_mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_bad_ethertype();
    test_write_nr_wrap();
    test_reset_mid_frame();
    test_long_hold();
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ecpri_rx.md
ECPRI_RX -- requirements
Module: ecpri_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM data byte width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, RAM address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: ports clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 recv_pkt  input  1  level; a frame is present in the receive RAM starting at address 0.
REQ-007 inp_data_fifo  input  DATA_WIDTH  reserved; ignored, no effect on behaviour.
REQ-008 addr_1/we_1/oe_1  output  ADDR_WIDTH/1/1  receive-frame RAM port; read only.
REQ-009 data_1  inout  DATA_WIDTH  receive-frame RAM data; never driven (always Z).
REQ-010 addr_0/we_0/oe_0  output  ADDR_WIDTH/1/1  header RAM port; write only.
REQ-011 data_0  inout  DATA_WIDTH  header RAM data; driven only while we_0=1, else Z.
REQ-012 addr_2/we_2/oe_2  output  ADDR_WIDTH/1/1  CPRI payload RAM port; write only.
REQ-013 data_2  inout  DATA_WIDTH  payload RAM data; driven only while we_2=1, else Z.
REQ-014 send_write_resp, send_read_resp  output  1  one-cycle response requests to the TX block.
REQ-015 resp_payload_len  output  DATA_WIDTH  response data length.

Function
REQ-016 RAM timing: synchronous read, data valid one cycle after address with oe=1, we=0; write at the clock edge where we=1.
REQ-017 FSM states: IDLE, RD_HDR, CHECK, WR_DATA, RESP, WAIT_LOW.
REQ-018 IDLE -> RD_HDR when recv_pkt=1.
REQ-019 RD_HDR: read bytes 0..29 with the address incremented every cycle; copy each byte into header RAM at the same address.
REQ-020 Byte map: 0-11 MACs; 12-13 ethertype; 14 revision byte; 15 message type; 16-17 payload size (BE); 18 RMA ID; 19 R/W[7:4], Req/Resp[3:0]; 20-21 element ID; 22-27 address (BE); 28-29 length (BE); 30+ write data.
REQ-021 CHECK: frame is valid only if ethertype=0xAEFE, byte14[7:4]=1, type=0x04, Req/Resp=0, R/W in {0,1,2} and length <= payload size - 12.
REQ-022 An invalid frame SHALL go to WAIT_LOW with no payload writes and no response pulses.
REQ-023 R/W=1 (write) or R/W=2 (write, no response): go to WR_DATA.
REQ-024 WR_DATA: write length bytes from frame offset 30 to payload RAM at address[15:0]+k, address wrapping modulo 2^16.
REQ-025 Length 0 SHALL skip WR_DATA.
REQ-026 RESP: write -> send_write_resp=1 for one cycle with resp_payload_len=0.
REQ-027 RESP: read -> send_read_resp=1 for one cycle with resp_payload_len=length[7:0]; no payload writes.
REQ-028 RESP: write-no-response -> no pulse.
REQ-029 resp_payload_len SHALL hold its value until the next RESP.
REQ-030 WAIT_LOW -> IDLE when recv_pkt=0; exactly one frame is processed per recv_pkt assertion.
REQ-031 At most one of we_0 and we_2 SHALL be active per cycle; we_1 SHALL be 0 always; oe_x=0 whenever we_x=1.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, all addresses 0, all we/oe 0, data ports Z, response pulses 0, resp_payload_len 0, also mid-frame.
REQ-033 After reset release, a frame restarts from byte 0.

Structure
REQ-034 Package ecpri_pkg SHALL hold the ethertype 0xAEFE, message type 4, R/W and Req/Resp codes, byte offsets and the state enum.
REQ-035 No sub-module: the RAMs are external ram_dp_sr_sw instances in the integration level.

Verification
REQ-036 Write request, addr 0x10, len 4, data AA BB CC DD -> payload[0x10..0x13]=AA..DD, one send_write_resp pulse, resp_payload_len=0.
REQ-037 Read request, len 8 -> send_read_resp pulse, resp_payload_len=8, we_2 never 1, header RAM[0..29] equals frame bytes.
REQ-038 Ethertype 0x0800 -> no pulses and no we_2; the header copy still occurs.
REQ-039 Write-no-response, len 2, addr 0xFFFF -> payload[0xFFFF] and payload[0x0000] written, no pulse.
REQ-040 reset low during RD_HDR -> outputs at reset values at once; after release with recv_pkt=1 the frame is reprocessed correctly.
REQ-041 recv_pkt held high for 200 cycles -> exactly one response pulse.
